// File: rtl/sys_array_ctrl.sv
// Job sequencer for an MxNxK systolic array: load operands, feed edge lanes, wait, drain results.
// Optional watchdog on FEED/WAIT enabled by defining SA_WDOG_EN.
module sys_array_ctrl #(
    parameter int unsigned M       = 2,
    parameter int unsigned N       = 3,
    parameter int unsigned K       = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [31:0]          ld_dat,
    output logic [M-1:0]         row_valid,
    input  logic [M-1:0]         row_ready,
    output logic [M*32-1:0]      row_dat,
    output logic [K-1:0]         col_valid,
    input  logic [K-1:0]         col_ready,
    output logic [K*32-1:0]      col_dat,
    output logic                 arr_clr,
    input  logic                 arr_done,
    input  logic                 arr_err,
    input  logic [M*K*32-1:0]    arr_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_dat,
    output logic                 res_last,
    output logic                 job_done,
    output logic                 job_err
);

    localparam int unsigned DW = 32;
    localparam int unsigned NA = M * N;
    localparam int unsigned NT = (M + K) * N;
    localparam int unsigned NR = M * K;
    localparam int unsigned PW = (NT > 1) ? $clog2(NT) : 1;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned QW = (NR > 1) ? $clog2(NR) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(NT - 1);
    localparam logic [CW-1:0] CTR_END = CW'(N);
    localparam logic [QW-1:0] Q_LAST  = QW'(NR - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FEED, S_WAIT, S_DRAIN, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [CW-1:0] row_ctr_q [M];
    logic [CW-1:0] row_ctr_d [M];
    logic [CW-1:0] col_ctr_q [K];
    logic [CW-1:0] col_ctr_d [K];
    logic [QW-1:0] q_q, q_d;
    logic [DW-1:0] op_q   [NT];
    logic [DW-1:0] op_d   [NT];
    logic [DW-1:0] snap_q [NR];
    logic [DW-1:0] snap_d [NR];
    logic          job_err_d, arr_clr_d, job_done_d, feed_done, wd_fire;

    // A lanes occupy op[0..NA-1], B lanes follow; a drained lane points at its base slot.
    function automatic logic [PW-1:0] op_idx(input int unsigned base, input logic [CW-1:0] ctr);
        return (ctr < CTR_END) ? PW'(base) + PW'(ctr) : PW'(base);
    endfunction

`ifdef SA_WDOG_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          any_hs;

    assign any_hs = (|(row_valid & row_ready)) || (|(col_valid & col_ready));

    // Idle-cycle counter for FEED/WAIT, restarted by any lane handshake.
    always_comb begin
        wd_d = '0;
        if ((state_q == S_FEED || state_q == S_WAIT) && !any_hs) begin
            wd_d = wd_q + WW'(1);
        end
    end

    assign wd_fire = (wd_d == WW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= (state_d != state_q) ? '0 : wd_d;
        end
    end
`else
    assign wd_fire = 1'b0;
    // TIMEOUT only matters with the watchdog built in.
    if (TIMEOUT == 0) begin : g_no_wdog
    end
`endif

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        row_ctr_d  = row_ctr_q;
        col_ctr_d  = col_ctr_q;
        q_d        = q_q;
        op_d       = op_q;
        snap_d     = snap_q;
        job_err_d  = job_err;
        arr_clr_d  = 1'b0;
        job_done_d = 1'b0;
        feed_done  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    p_d       = '0;
                    job_err_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (ld_valid && ld_ready) begin
                    op_d[p_q] = ld_dat;
                    if (p_q == P_LAST) begin
                        arr_clr_d = 1'b1;
                        state_d   = S_FEED;
                        for (int i = 0; i < M; i++) row_ctr_d[i] = '0;
                        for (int j = 0; j < K; j++) col_ctr_d[j] = '0;
                    end else begin
                        p_d = p_q + PW'(1);
                    end
                end
            end
            S_FEED: begin
                for (int i = 0; i < M; i++) begin
                    if (row_valid[i] && row_ready[i]) row_ctr_d[i] = row_ctr_q[i] + CW'(1);
                    if (row_ctr_d[i] != CTR_END) feed_done = 1'b0;
                end
                for (int j = 0; j < K; j++) begin
                    if (col_valid[j] && col_ready[j]) col_ctr_d[j] = col_ctr_q[j] + CW'(1);
                    if (col_ctr_d[j] != CTR_END) feed_done = 1'b0;
                end
                if (arr_err || (!feed_done && wd_fire)) begin
                    state_d   = S_ERR;
                    job_err_d = 1'b1;
                end else if (feed_done) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (arr_err) begin
                    state_d   = S_ERR;
                    job_err_d = 1'b1;
                end else if (arr_done) begin
                    for (int r = 0; r < NR; r++) snap_d[r] = arr_out[r*DW +: DW];
                    q_d     = '0;
                    state_d = S_DRAIN;
                end else if (wd_fire) begin
                    state_d   = S_ERR;
                    job_err_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (res_valid && res_ready) begin
                    if (q_q == Q_LAST) begin
                        job_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        q_d = q_q + QW'(1);
                    end
                end
            end
            S_ERR: begin
                job_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State plus outputs, the latter registered from next-state values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            p_q       <= '0;
            q_q       <= '0;
            row_ctr_q <= '{default: '0};
            col_ctr_q <= '{default: '0};
            op_q      <= '{default: '0};
            snap_q    <= '{default: '0};
            busy      <= 1'b0;
            ld_ready  <= 1'b0;
            row_valid <= '0;
            row_dat   <= '0;
            col_valid <= '0;
            col_dat   <= '0;
            arr_clr   <= 1'b0;
            res_valid <= 1'b0;
            res_dat   <= '0;
            res_last  <= 1'b0;
            job_done  <= 1'b0;
            job_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            q_q       <= q_d;
            row_ctr_q <= row_ctr_d;
            col_ctr_q <= col_ctr_d;
            op_q      <= op_d;
            snap_q    <= snap_d;
            busy      <= (state_d != S_IDLE);
            ld_ready  <= (state_d == S_LOAD);
            arr_clr   <= arr_clr_d;
            job_done  <= job_done_d;
            job_err   <= job_err_d;
            for (int i = 0; i < M; i++) begin
                row_valid[i]        <= (state_d == S_FEED) && (row_ctr_d[i] < CTR_END);
                row_dat[i*DW +: DW] <= ((state_d == S_FEED) && (row_ctr_d[i] < CTR_END)) ?
                                       op_d[op_idx(i * N, row_ctr_d[i])] : '0;
            end
            for (int j = 0; j < K; j++) begin
                col_valid[j]        <= (state_d == S_FEED) && (col_ctr_d[j] < CTR_END);
                col_dat[j*DW +: DW] <= ((state_d == S_FEED) && (col_ctr_d[j] < CTR_END)) ?
                                       op_d[op_idx(NA + j * N, col_ctr_d[j])] : '0;
            end
            res_valid <= (state_d == S_DRAIN);
            res_dat   <= (state_d == S_DRAIN) ? snap_d[q_d] : '0;
            res_last  <= (state_d == S_DRAIN) && (q_d == Q_LAST);
        end
    end

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl (M=2,N=3,K=2); watchdog case built only with SA_WDOG_EN.
module tb_sys_array_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy;
    logic         ld_valid;
    logic         ld_ready;
    logic [31:0]  ld_dat;
    logic [1:0]   row_valid;
    logic [1:0]   row_ready;
    logic [63:0]  row_dat;
    logic [1:0]   col_valid;
    logic [1:0]   col_ready;
    logic [63:0]  col_dat;
    logic         arr_clr;
    logic         arr_done;
    logic         arr_err;
    logic [127:0] arr_out;
    logic         res_valid;
    logic         res_ready;
    logic [31:0]  res_dat;
    logic         res_last;
    logic         job_done;
    logic         job_err;

    sys_array_ctrl #(.M(2), .N(3), .K(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dat(ld_dat),
        .row_valid(row_valid), .row_ready(row_ready), .row_dat(row_dat),
        .col_valid(col_valid), .col_ready(col_ready), .col_dat(col_dat),
        .arr_clr(arr_clr), .arr_done(arr_done), .arr_err(arr_err), .arr_out(arr_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_dat(res_dat), .res_last(res_last),
        .job_done(job_done), .job_err(job_err)
    );

    always #5 clk = ~clk;

    // Single-precision 1.0 .. 6.0
    logic [31:0]  fw [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};
    // 14.0, 32.0, 32.0, 77.0 with element 0 in the low word
    localparam logic [127:0] NOM = {32'h429A0000, 32'h42000000, 32'h42000000, 32'h41600000};
    localparam logic [127:0] PAT = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    int tests = 0;
    int fails = 0;

    logic [31:0] row0_q[$], row1_q[$], col0_q[$], col1_q[$], res_dq[$];
    logic        res_lq[$];
    int          done_cnt = 0;
    int          clr_cnt  = 0;

    // Record every handshake and pulse as the DUT sees them at the edge.
    always @(posedge clk) begin
        if (row_valid[0] && row_ready[0]) row0_q.push_back(row_dat[31:0]);
        if (row_valid[1] && row_ready[1]) row1_q.push_back(row_dat[63:32]);
        if (col_valid[0] && col_ready[0]) col0_q.push_back(col_dat[31:0]);
        if (col_valid[1] && col_ready[1]) col1_q.push_back(col_dat[63:32]);
        if (res_valid && res_ready) begin
            res_dq.push_back(res_dat);
            res_lq.push_back(res_last);
        end
        if (job_done) done_cnt++;
        if (arr_clr) clr_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL tb_timeout: run exceeded time limit");
        $fatal(1, "tb timeout");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ldready"}, ld_ready, 1);
        check({tag, "_err_clr"}, job_err, 0);
    endtask

    task automatic load_all(input string tag, input bit bubble, input bit start_on_last);
        logic ok;
        ok = 1'b1;
        for (int p = 0; p < 12; p++) begin
            ld_valid = 1'b1;
            ld_dat   = fw[p % 6];
            if (start_on_last && p == 11) start = 1'b1;
            if (!ld_ready) ok = 1'b0;
            tick();
            start = 1'b0;
            if (bubble && p == 5) begin
                ld_valid = 1'b0;
                tick();
            end
        end
        ld_valid = 1'b0;
        ld_dat   = '0;
        check({tag, "_ld_ready_held"}, ok, 1);
        check({tag, "_arr_clr"}, arr_clr, 1);
        check({tag, "_ld_ready_off"}, ld_ready, 0);
        check({tag, "_feed_valid"}, {row_valid, col_valid}, 4'hF);
        check({tag, "_row_dat0"}, row_dat, {32'h40800000, 32'h3F800000});
        check({tag, "_col_dat0"}, col_dat, {32'h40800000, 32'h3F800000});
    endtask

    task automatic check_streams(input string tag, input int r0, input int r1, input int c0, input int c1);
        check({tag, "_lane_counts"}, {row0_q.size() - r0, row1_q.size() - r1, col0_q.size() - c0, col1_q.size() - c1},
              {32'd3, 32'd3, 32'd3, 32'd3});
        for (int s = 0; s < 3; s++) begin
            check({tag, "_row0"}, row0_q[r0 + s], fw[s]);
            check({tag, "_row1"}, row1_q[r1 + s], fw[s + 3]);
            check({tag, "_col0"}, col0_q[c0 + s], fw[s]);
            check({tag, "_col1"}, col1_q[c1 + s], fw[s + 3]);
        end
    endtask

    task automatic check_results(input string tag, input int rb, input logic [127:0] exp);
        check({tag, "_res_count"}, res_dq.size() - rb, 4);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_res_dat"}, res_dq[rb + k], exp[k*32 +: 32]);
            check({tag, "_res_last"}, res_lq[rb + k], (k == 3) ? 1'b1 : 1'b0);
        end
    endtask

    // Drain until idle; with toggle, res_ready alternates and stalled cycles must hold data.
    task automatic drain(input string tag, input bit toggle);
        int          b;
        logic [31:0] hd;
        logic        hl;
        b = 0;
        while (busy && b < 40) begin
            res_ready = toggle ? ~b[0] : 1'b1;
            if (toggle && b == 2) start = 1'b1;
            hd = res_dat;
            hl = res_last;
            tick();
            start = 1'b0;
            if (!res_ready) begin
                check({tag, "_hold"}, {res_valid, res_last, res_dat}, {1'b1, hl, hd});
            end
            b++;
        end
        res_ready = 1'b1;
        check({tag, "_drain_end"}, {busy, job_done}, 2'b01);
        tick();
        check({tag, "_done_pulse"}, job_done, 0);
    endtask

    task automatic run_nominal(input string tag, input bit start_on_last);
        int r0, r1, c0, c1, rb, d0, k0;
        r0 = row0_q.size(); r1 = row1_q.size(); c0 = col0_q.size(); c1 = col1_q.size();
        rb = res_dq.size(); d0 = done_cnt; k0 = clr_cnt;
        row_ready = 2'b11; col_ready = 2'b11; res_ready = 1'b1;
        do_start(tag);
        load_all(tag, 1'b0, start_on_last);
        tick(); tick(); tick();
        check({tag, "_wait_valids"}, {row_valid, col_valid, arr_clr, busy}, 6'b000001);
        check_streams(tag, r0, r1, c0, c1);
        tick();
        check({tag, "_wait_hold"}, {res_valid, busy}, 2'b01);
        arr_out  = NOM;
        arr_done = 1'b1;
        tick();
        arr_done = 1'b0;
        check({tag, "_first_res"}, {res_valid, res_last, res_dat}, {1'b1, 1'b0, 32'h41600000});
        drain(tag, 1'b0);
        check_results(tag, rb, NOM);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
        check({tag, "_clr_cnt"}, clr_cnt - k0, 1);
        check({tag, "_job_err"}, job_err, 0);
    endtask

    initial begin
        int r0, r1, c0, c1, rb, d0;
        rst = 1'b1; start = 0; ld_valid = 0; ld_dat = 0; row_ready = 0; col_ready = 0;
        arr_done = 0; arr_err = 0; arr_out = 0; res_ready = 0;
        tick(); tick();
        check("rst_ctrl", {busy, ld_ready, arr_clr, res_valid, res_last, job_done, job_err}, 7'b0);
        check("rst_lanes", {row_valid, col_valid, row_dat, col_dat, res_dat}, '0);
        rst = 1'b0;
        tick();
        check("idle_quiet", {busy, ld_ready}, 2'b00);

        // Nominal job; start raised alongside the final load word
        run_nominal("nom", 1'b1);

        // Backpressure on row lane 1 and res_ready, with start pulses in FEED and DRAIN
        r0 = row0_q.size(); r1 = row1_q.size(); c0 = col0_q.size(); c1 = col1_q.size();
        rb = res_dq.size(); d0 = done_cnt;
        do_start("bp");
        load_all("bp", 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        row_ready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_lane1_hold", {row_valid[1], row_dat[63:32]}, {1'b1, 32'h40A00000});
        end
        check("bp_others_done", {row_valid, col_valid}, 4'b1000);
        row_ready = 2'b11;
        tick();
        check("bp_lane1_next", {row_valid, row_dat[63:32]}, {2'b10, 32'h40C00000});
        tick();
        check("bp_wait", {row_valid, col_valid, busy}, 5'b00001);
        check_streams("bp", r0, r1, c0, c1);
        arr_out  = PAT;
        arr_done = 1'b1;
        tick();
        arr_done = 1'b0;
        drain("bp", 1'b1);
        check_results("bp", rb, PAT);
        check("bp_done_cnt", done_cnt - d0, 1);
        tick();
        check("bp_start_ignored", {busy, ld_ready}, 2'b00);

        // Array error while waiting
        rb = res_dq.size(); d0 = done_cnt;
        do_start("err");
        load_all("err", 1'b0, 1'b0);
        tick(); tick(); tick();
        arr_err = 1'b1;
        tick();
        arr_err = 1'b0;
        check("err_state", {job_err, busy, res_valid, job_done}, 4'b1100);
        tick();
        check("err_done", {job_done, busy, job_err}, 3'b101);
        tick();
        check("err_sticky", {job_done, job_err, res_valid}, 3'b010);
        check("err_no_res", res_dq.size() - rb, 0);
        check("err_done_cnt", done_cnt - d0, 1);
        do_start("err_clear");

        // Reset part-way through a load, then a clean job
        for (int p = 0; p < 4; p++) begin
            ld_valid = 1'b1;
            ld_dat   = fw[p];
            tick();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_ctrl", {busy, ld_ready, arr_clr, res_valid, res_last, job_done, job_err}, 7'b0);
        check("mid_rst_lanes", {row_valid, col_valid, row_dat, col_dat, res_dat}, '0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);
        run_nominal("after_rst", 1'b0);

`ifdef SA_WDOG_EN
        // Watchdog with array never finishing
        do_start("wd");
        load_all("wd", 1'b0, 1'b0);
        tick(); tick(); tick();
        for (int k = 0; k < 15; k++) tick();
        check("wd_before", {busy, job_err}, 2'b10);
        tick();
        check("wd_fired", {busy, job_err, res_valid}, 3'b110);
        tick();
        check("wd_done", {job_done, busy, job_err}, 3'b101);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
